// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues sequential word addresses to a
// synchronous instruction memory (1-cycle read latency). Returned words go
// into a 2-entry {pc, inst} FIFO, and decode drains that FIFO with a
// valid/ready handshake. A redirect flushes everything buffered or in flight
// and restarts fetch at the new target.
//
// Optional feature:
//   FETCH_PERF_EN  adds if_fetch_cnt, a 32-bit count of accepted handshakes.
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous, active-high reset
//   imu_addr        out  16  byte fetch address (always equals pc_q)
//   imu_dout        in   32  instruction word for the previous cycle's address
//   redirect_valid  in   1   flush and restart at redirect_pc
//   redirect_pc     in   16  redirect target (low two bits ignored)
//   id_ready        in   1   decode accepts the head instruction
//   if_valid        out  1   head instruction available
//   if_pc           out  16  PC of the head instruction (0 when FIFO empty)
//   if_inst         out  32  head instruction word (0 when FIFO empty)
//   if_fetch_cnt    out  32  accepted-handshake count (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imu_addr,
  input  logic [31:0] imu_dout,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] if_fetch_cnt
`endif
);

  // Control state
  logic [15:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  // Data state (no reset needed: qualified by inflight_q / count_q)
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic [15:0] fifo_pc_q   [2];
  logic [15:0] fifo_pc_d   [2];
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_inst_d [2];

  logic        pop;
  logic        write;
  logic        issue;
  logic [2:0]  occ_after;

  assign imu_addr = pc_q;

  // The handshake is suppressed while a redirect flushes the FIFO.
  assign if_valid = (count_q != 2'd0) & ~redirect_valid;
  assign if_pc    = (count_q != 2'd0) ? fifo_pc_q[rd_ptr_q]   : 16'h0000;
  assign if_inst  = (count_q != 2'd0) ? fifo_inst_q[rd_ptr_q] : 32'h0000_0000;

  assign pop   = if_valid & id_ready;
  assign write = inflight_q & ~redirect_valid;

  // Occupancy at the end of this cycle. A new issue is allowed only if its
  // response, which lands next cycle, is guaranteed a free FIFO slot.
  assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = ~redirect_valid & (occ_after < 3'd2);

  always_comb begin
    pc_d           = pc_q;
    inflight_d     = inflight_q;
    inflight_pc_d  = inflight_pc_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    fifo_pc_d[0]   = fifo_pc_q[0];
    fifo_pc_d[1]   = fifo_pc_q[1];
    fifo_inst_d[0] = fifo_inst_q[0];
    fifo_inst_d[1] = fifo_inst_q[1];

    if (redirect_valid) begin
      // Drop the buffered entries and the in-flight response.
      pc_d       = redirect_pc & 16'hFFFC;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 16'd4;
      end
      if (write) begin
        fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
        fifo_inst_d[wr_ptr_q] = imu_dout;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, write} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC & 16'hFFFC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q  <= inflight_pc_d;
    fifo_pc_q[0]   <= fifo_pc_d[0];
    fifo_pc_q[1]   <= fifo_pc_d[1];
    fifo_inst_q[0] <= fifo_inst_d[0];
    fifo_inst_q[1] <= fifo_inst_d[1];
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Counts accepted handshakes. A redirect does not clear it.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (pop) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign if_fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A memory model answers every address with
// {16'hA5A5, addr} one cycle later. A reference model checks the outputs on
// every cycle and describes the stream in terms of the observable behaviour
// only:
//   - After a restart (reset or redirect), if_valid is 0 for the first two
//     cycles and 1 from then on, unless another restart occurs.
//   - While a redirect is asserted, if_valid is 0.
//   - Delivered PCs follow the restart target in steps of 4 (mod 2^16), each
//     with inst = {A5A5, pc}, and advance only on a handshake.
//   - With the FIFO empty, if_pc and if_inst read 0.
//   - The first address after a restart is the restart target.
// A few literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imu_addr;
  logic [31:0] imu_dout = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] if_fetch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imu_addr       (imu_addr),
    .imu_dout       (imu_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
`ifdef FETCH_PERF_EN
    ,
    .if_fetch_cnt   (if_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory
  always @(posedge clk) imu_dout <= {16'hA5A5, imu_addr};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic        armed = 1'b0;
  logic [15:0] exp_pc = 16'h0;
  int          since = 0;
  logic        addr_pending = 1'b0;
  logic [15:0] addr_exp = 16'h0;
  logic [31:0] perf_exp = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      armed        = 1'b1;
      exp_pc       = RST_PC;
      since        = 0;
      addr_pending = 1'b1;
      addr_exp     = RST_PC;
      perf_exp     = 32'h0;
    end else if (armed) begin
`ifdef FETCH_PERF_EN
      chk("perf_cnt", if_fetch_cnt, perf_exp);
`endif
      if (addr_pending) begin
        chk("restart_addr", {16'h0, imu_addr}, {16'h0, addr_exp});
        addr_pending = 1'b0;
      end
      if (redirect_valid) begin
        chk("redirect_valid_low", {31'h0, if_valid}, 32'h0);
        exp_pc       = redirect_pc & 16'hFFFC;
        since        = 0;
        addr_pending = 1'b1;
        addr_exp     = exp_pc;
      end else begin
        chk("valid", {31'h0, if_valid}, {31'h0, (since >= 2)});
        if (if_valid) begin
          chk("if_pc", {16'h0, if_pc}, {16'h0, exp_pc});
          chk("if_inst", if_inst, {16'hA5A5, exp_pc});
          if (id_ready) begin
            exp_pc   = exp_pc + 16'd4;
            perf_exp = perf_exp + 32'd1;
          end
        end else begin
          chk("empty_pc", {16'h0, if_pc}, 32'h0);
          chk("empty_inst", if_inst, 32'h0);
        end
        since++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic r, input logic rv, input logic [15:0] rp, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rdy;
    #1;
  endtask

  logic [19:0] rdy_pat;

  initial begin
    rdy_pat = 20'b1011_0010_1110_0110_1001;

    cyc(1, 0, 16'h0, 1);
    cyc(1, 0, 16'h0, 1);

    // Reset release, streaming, then a 5-cycle stall
    cyc(0, 0, 16'h0, 1);
    chk("lit_addr_c0", {16'h0, imu_addr}, 32'h0000_3000);
    chk("lit_valid_c0", {31'h0, if_valid}, 32'h0);
    cyc(0, 0, 16'h0, 1);
    chk("lit_addr_c1", {16'h0, imu_addr}, 32'h0000_3004);
    cyc(0, 0, 16'h0, 1);
    chk("lit_valid_c2", {31'h0, if_valid}, 32'h1);
    chk("lit_pc_c2", {16'h0, if_pc}, 32'h0000_3000);
    chk("lit_inst_c2", if_inst, 32'hA5A5_3000);
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 0);
    chk("lit_stall_addr", {16'h0, imu_addr}, 32'h0000_300C);
    chk("lit_stall_pc", {16'h0, if_pc}, 32'h0000_3004);
    cyc(0, 0, 16'h0, 1);
    chk("lit_rel_pc0", {16'h0, if_pc}, 32'h0000_3004);
    cyc(0, 0, 16'h0, 1);
    chk("lit_rel_pc1", {16'h0, if_pc}, 32'h0000_3008);
    cyc(0, 0, 16'h0, 1);
    chk("lit_rel_pc2", {16'h0, if_pc}, 32'h0000_300C);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 1);

    // Redirect to 0102 (low bits dropped)
    cyc(0, 1, 16'h0102, 1);
    cyc(0, 0, 16'h0, 1);
    chk("lit_redir_addr", {16'h0, imu_addr}, 32'h0000_0100);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("lit_redir_valid", {31'h0, if_valid}, 32'h1);
    chk("lit_redir_pc", {16'h0, if_pc}, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1);

    // Back-to-back redirects: the later one wins
    cyc(0, 1, 16'h0200, 1);
    cyc(0, 1, 16'h0300, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 1);
    chk("lit_redir2_pc", {16'h0, if_pc}, 32'h0000_0308);

    // Wrap at the top of the address space
    cyc(0, 1, 16'hFFFC, 1);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("lit_wrap_pc0", {16'h0, if_pc}, 32'h0000_FFFC);
    cyc(0, 0, 16'h0, 1);
    chk("lit_wrap_pc1", {16'h0, if_pc}, 32'h0000_0000);
    chk("lit_wrap_inst1", if_inst, 32'hA5A5_0000);
    cyc(0, 0, 16'h0, 1);
    chk("lit_wrap_pc2", {16'h0, if_pc}, 32'h0000_0004);

    // Irregular ready pattern
    for (int i = 0; i < 20; i++) cyc(0, 0, 16'h0, rdy_pat[i]);

    // Fill the pipeline, then reset with a redirect also asserted
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cyc(1, 1, 16'h0800, 1);
    cyc(0, 0, 16'h0, 1);
    chk("lit_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("lit_rst_addr", {16'h0, imu_addr}, 32'h0000_3000);
`ifdef FETCH_PERF_EN
    chk("lit_rst_perf", if_fetch_cnt, 32'h0);
`endif
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("lit_rst_pc", {16'h0, if_pc}, 32'h0000_3000);

    // Ten handshakes spanning one redirect, for the perf counter
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 1);
    cyc(0, 1, 16'h0400, 1);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 0);
`ifdef FETCH_PERF_EN
    chk("lit_perf10", if_fetch_cnt, 32'd10);
`endif
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 1);

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
